// File: rtl/btn_debounce_pkg.sv
// Shared types for the push-button debouncer: per-channel FSM state encoding.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    StLo   = 2'd0,
    StRise = 2'd1,
    StHi   = 2'd2,
    StFall = 2'd3
  } deb_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: input synchroniser, 4-state acceptance FSM and run-length counter.
module debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  deb_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   clean_q, rise_q, fall_q;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= StLo;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        StLo: begin
          if (sync) begin
            state_q <= StRise;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        StRise: begin
          // Any reversal before the terminal count throws the partial run away.
          if (!sync) begin
            state_q <= StLo;
            cnt_q   <= '0;
          end else if (cnt_q == CntMax) begin
            state_q <= StHi;
            clean_q <= 1'b1;
            rise_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StHi: begin
          if (!sync) begin
            state_q <= StFall;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        StFall: begin
          if (sync) begin
            state_q <= StHi;
            cnt_q   <= '0;
          end else if (cnt_q == CntMax) begin
            state_q <= StLo;
            clean_q <= 1'b0;
            fall_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/btn_debounce.sv
// N_CH independent button debouncers; btn_clean[0]/[1] feed the a/b inputs of the gate stage.
module btn_debounce #(
  parameter int unsigned N_CH            = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_clean,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .clean(btn_clean[i]),
      .rise (btn_rise[i]),
      .fall (btn_fall[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (N_CH=2, S=2, D=4); expected outputs queued per edge.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn_raw = 2'b11;
  logic [1:0] btn_clean, btn_rise, btn_fall;

  logic [5:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  btn_debounce #(
    .N_CH           (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_clean(btn_clean),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  // Drive one cycle, queue the expected {clean,rise,fall} after the edge, then check it.
  task automatic cyc(input string tag, input logic [1:0] raw, input logic r,
                     input logic [1:0] c, input logic [1:0] ri, input logic [1:0] fa);
    logic [5:0] got, exp;
    btn_raw = raw;
    rst     = r;
    exp_q.push_back({c, ri, fa});
    @(posedge clk);
    @(negedge clk);
    got = {btn_clean, btn_rise, btn_fall};
    exp = exp_q.pop_front();
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: clean/rise/fall got %b_%b_%b expected %b_%b_%b", tag,
             got[5:4], got[3:2], got[1:0], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic run(input string tag, input int n, input logic [1:0] raw,
                     input logic [1:0] c, input logic [1:0] ri, input logic [1:0] fa);
    for (int i = 0; i < n; i++) cyc(tag, raw, 1'b0, c, ri, fa);
  endtask

  initial begin
    @(negedge clk);
    // 1: reset with both raw inputs high, then acceptance on edge 6
    cyc("rst_hold0", 2'b11, 1'b1, 2'b00, 2'b00, 2'b00);
    cyc("rst_hold1", 2'b11, 1'b1, 2'b00, 2'b00, 2'b00);
    run("rst_wait", 5, 2'b11, 2'b00, 2'b00, 2'b00);
    cyc("rst_edge6", 2'b11, 1'b0, 2'b11, 2'b11, 2'b00);
    cyc("rst_edge7", 2'b11, 1'b0, 2'b11, 2'b00, 2'b00);

    // 5: simultaneous release on both channels
    run("rel_wait", 5, 2'b00, 2'b11, 2'b00, 2'b00);
    cyc("rel_edge6", 2'b00, 1'b0, 2'b00, 2'b00, 2'b11);
    cyc("rel_edge7", 2'b00, 1'b0, 2'b00, 2'b00, 2'b00);

    // 2: clean press on ch0 only
    run("press_wait", 5, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc("press_edge6", 2'b01, 1'b0, 2'b01, 2'b01, 2'b00);
    run("press_hold", 3, 2'b01, 2'b01, 2'b00, 2'b00);
    run("press_rel_wait", 5, 2'b00, 2'b01, 2'b00, 2'b00);
    cyc("press_rel_edge6", 2'b00, 1'b0, 2'b00, 2'b00, 2'b01);
    cyc("press_rel_edge7", 2'b00, 1'b0, 2'b00, 2'b00, 2'b00);

    // 3: bounce on ch0 (1,0,1,0 then hold 1); final rise at edge 5 -> clean at edge 10
    cyc("bounce_e1", 2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    cyc("bounce_e2", 2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    cyc("bounce_e3", 2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    cyc("bounce_e4", 2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    run("bounce_wait", 5, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc("bounce_e10", 2'b01, 1'b0, 2'b01, 2'b01, 2'b00);
    cyc("bounce_e11", 2'b01, 1'b0, 2'b01, 2'b00, 2'b00);

    // 4: three-cycle glitch on ch1 must be rejected
    run("glitch_hi", 3, 2'b11, 2'b01, 2'b00, 2'b00);
    run("glitch_lo", 8, 2'b01, 2'b01, 2'b00, 2'b00);

    // 6: reset mid-count on ch0
    run("mid_clr_wait", 5, 2'b00, 2'b01, 2'b00, 2'b00);
    cyc("mid_clr_edge6", 2'b00, 1'b0, 2'b00, 2'b00, 2'b01);
    run("mid_count", 3, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc("mid_rst", 2'b01, 1'b1, 2'b00, 2'b00, 2'b00);
    run("mid_recount", 5, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc("mid_edge6", 2'b01, 1'b0, 2'b01, 2'b01, 2'b00);
    cyc("mid_edge7", 2'b01, 1'b0, 2'b01, 2'b00, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
